// File: rtl/freq_divider.sv
// Integer clock divider: clk_out is a registered square wave of period DIV clk_in cycles,
// high for floor(DIV/2) cycles then low for the rest, rising on the first edge after reset.
module freq_divider #(
    parameter logic [27:0] DIV = 28'd12000000
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic clk_out
);

    localparam logic [27:0] HALF   = DIV >> 1;
    localparam bit          ACTIVE = (DIV >= 28'd2);
    // Wrap point resolved at elaboration so DIV of 0 or 1 can never underflow.
    localparam logic [27:0] LAST   = ACTIVE ? (DIV - 28'd1) : 28'd0;

    logic [27:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (!ACTIVE) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= (cnt == LAST) ? '0 : cnt + 28'd1;
            clk_out <= (cnt < HALF);
        end
    end

endmodule

// File: tb/tb_freq_divider.sv
// Self-checking bench: five dividers (15, 30, 60, 2, 1) on one clock, compared every cycle
// against an edge-count model with randomized asynchronous reset pulses.
`timescale 1ns/1ps
module tb_freq_divider;

    logic clk_in;
    logic rst_n;
    logic o15, o30, o60, o2, o1;

    freq_divider #(.DIV(28'd15)) u15 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(o15));
    freq_divider #(.DIV(28'd30)) u30 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(o30));
    freq_divider #(.DIV(28'd60)) u60 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(o60));
    freq_divider #(.DIV(28'd2))  u2  (.clk_in(clk_in), .rst_n(rst_n), .clk_out(o2));
    freq_divider #(.DIV(28'd1))  u1  (.clk_in(clk_in), .rst_n(rst_n), .clk_out(o1));

    int tests_run    = 0;
    int tests_failed = 0;
    int edges;          // rising edges seen since the last reset release

    // 12 MHz board clock
    initial begin
        clk_in = 1'b0;
        forever #41.667 clk_in = ~clk_in;
    end

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int div_of(int i);
        case (i)
            0: return 15;
            1: return 30;
            2: return 60;
            3: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic out_of(int i);
        case (i)
            0: return o15;
            1: return o30;
            2: return o60;
            3: return o2;
            default: return o1;
        endcase
    endfunction

    // Value after the k-th edge: high during the first floor(DIV/2) edges of each period.
    function automatic logic model_out(int div, int k);
        if (k == 0 || div < 2) return 1'b0;
        return ((k - 1) % div) < (div / 2);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #10;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (out_of(i) !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_async div%0d: got %b expected 0", div_of(i), out_of(i));
            end
        end
        repeat (4) begin
            @(negedge clk_in);
            for (int i = 0; i < 5; i++) begin
                tests_run++;
                if (out_of(i) !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL reset_hold div%0d: got %b expected 0", div_of(i), out_of(i));
                end
            end
        end
    endtask

    // Release at a falling edge, then run 3*60 cycles checking waveforms, period and phase.
    task automatic test_periods();
        int last_rise15, last_rise60, rises15;
        logic prev15, prev60;
        last_rise15 = -1; last_rise60 = -1; rises15 = 0;
        prev15 = 1'b0; prev60 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk_in);
        tests_run++;
        if ({o15, o30, o60, o2, o1} !== 5'b11110) begin
            tests_failed++;
            $display("FAIL first_edge: got %b expected 11110", {o15, o30, o60, o2, o1});
        end
        for (int c = 1; c <= 180; c++) begin
            if (c > 1) @(negedge clk_in);
            for (int i = 0; i < 5; i++) begin
                tests_run++;
                if (out_of(i) !== model_out(div_of(i), edges)) begin
                    tests_failed++;
                    $display("FAIL wave div%0d edge %0d: got %b expected %b",
                             div_of(i), edges, out_of(i), model_out(div_of(i), edges));
                end
            end
            tests_run++;
            if (u15.cnt >= 28'd15 || u30.cnt >= 28'd30 || u60.cnt >= 28'd60 ||
                u2.cnt >= 28'd2 || u1.cnt !== 28'd0) begin
                tests_failed++;
                $display("FAIL cnt_range edge %0d: got %0d/%0d/%0d/%0d/%0d expected below DIV",
                         edges, u15.cnt, u30.cnt, u60.cnt, u2.cnt, u1.cnt);
            end
            if (o15 && !prev15) begin
                if (last_rise15 >= 0) begin
                    tests_run++;
                    if (edges - last_rise15 != 15) begin
                        tests_failed++;
                        $display("FAIL period15: got %0d expected 15", edges - last_rise15);
                    end
                end
                last_rise15 = edges;
                rises15++;
            end
            if (o60 && !prev60) begin
                tests_run++;
                if (!o15 || (rises15 % 4) != 1) begin
                    tests_failed++;
                    $display("FAIL align60 edge %0d: got rise count %0d expected 4n+1", edges, rises15);
                end
                if (last_rise60 >= 0) begin
                    tests_run++;
                    if (edges - last_rise60 != 60) begin
                        tests_failed++;
                        $display("FAIL period60: got %0d expected 60", edges - last_rise60);
                    end
                end
                last_rise60 = edges;
            end
            prev15 = o15;
            prev60 = o60;
        end
    endtask

    // Async reset mid high phase of DIV=60, held 3 cycles, then verify restart phase.
    task automatic test_mid_reset();
        while (!(o60 && edges % 60 == 10)) @(negedge clk_in);
        #($urandom_range(30, 5));
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o15, o30, o60, o2, o1} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL mid_reset_async: got %b expected 00000", {o15, o30, o60, o2, o1});
        end
        repeat (3) @(negedge clk_in);
        tests_run++;
        if ({o15, o30, o60, o2, o1} !== 5'b00000 || u60.cnt !== 28'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_hold: got %b cnt %0d expected 00000 cnt 0",
                     {o15, o30, o60, o2, o1}, u60.cnt);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk_in);
            for (int i = 0; i < 5; i++) begin
                tests_run++;
                if (out_of(i) !== model_out(div_of(i), edges)) begin
                    tests_failed++;
                    $display("FAIL restart div%0d edge %0d: got %b expected %b",
                             div_of(i), edges, out_of(i), model_out(div_of(i), edges));
                end
            end
        end
    endtask

    // Random run lengths separated by random-length, randomly-timed async resets.
    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int run;
            run = $urandom_range(140, 1);
            for (int c = 0; c < run; c++) begin
                @(negedge clk_in);
                for (int i = 0; i < 5; i++) begin
                    tests_run++;
                    if (out_of(i) !== model_out(div_of(i), edges)) begin
                        tests_failed++;
                        $display("FAIL random it%0d div%0d edge %0d: got %b expected %b",
                                 it, div_of(i), edges, out_of(i), model_out(div_of(i), edges));
                    end
                end
            end
            #($urandom_range(35, 2));
            rst_n = 1'b0;
            #1;
            tests_run++;
            if ({o15, o30, o60, o2, o1} !== 5'b00000) begin
                tests_failed++;
                $display("FAIL random_reset it%0d: got %b expected 00000", it, {o15, o30, o60, o2, o1});
            end
            repeat ($urandom_range(4, 1)) @(negedge clk_in);
            rst_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_periods();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
